// File: rtl/shake_eta_sampler.sv
// Nibble rejection sampler between the SHAKE256 squeeze port and the
// polynomial store. It latches one XOF block and requests the next one right
// away, then scans the block one nibble per cycle. Each nibble is either
// rejected or mapped to a small coefficient in [-ETA, ETA], and accepted
// coefficients go out on a valid/ready stream until N_COEF have been sent.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_start          pulse that starts a new polynomial and aborts any current run
//   o_busy           high while a polynomial is being produced
//   o_done           one-cycle pulse after the final coefficient handshake
//   o_squeeze_req    one-cycle pulse that asks the XOF for its next block
//   i_squeeze_valid  an XOF block is present on i_squeeze_data
//   i_squeeze_data   XOF block; byte k is bits [8k+7:8k]
//   o_coef_valid     o_coef / o_coef_idx hold a coefficient
//   o_coef           coefficient, two's complement
//   o_coef_idx       coefficient index 0..N_COEF-1
//   i_coef_ready     consumer accepts the coefficient on offer
module shake_eta_sampler #(
    parameter int unsigned OUTPUT_LEN_BYTES = 128,
    parameter int unsigned ETA              = 2,    // 2 or 4
    parameter int unsigned N_COEF           = 256,
    parameter int unsigned COEF_W           = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_squeeze_req,
    input  logic                          i_squeeze_valid,
    input  logic [OUTPUT_LEN_BYTES*8-1:0] i_squeeze_data,
    output logic                          o_coef_valid,
    output logic [COEF_W-1:0]             o_coef,
    output logic [7:0]                    o_coef_idx,
    input  logic                          i_coef_ready
);

    localparam int unsigned BLK_W = OUTPUT_LEN_BYTES * 8;
    localparam int unsigned N_NIB = 2 * OUTPUT_LEN_BYTES;
    localparam int unsigned PTR_W = $clog2(N_NIB);
    localparam int unsigned CNT_W = $clog2(N_COEF + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        SCAN     = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    state_e              state_q;
    logic [BLK_W-1:0]    buf_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                req_q;
    logic                valid_q;
    logic [COEF_W-1:0]   coef_q;
    logic [7:0]          idx_q;

    logic                hs_c;
    logic                adv_c;
    logic                last_nib_c;
    logic                last_coef_c;
    logic [3:0]          nib_c;
    logic [3:0]          mod5_c;
    logic                nib_ok_c;
    logic [COEF_W-1:0]   nib_coef_c;

    // Handshake / advance qualifiers for the current cycle.
    assign hs_c        = valid_q && i_coef_ready;
    assign adv_c       = !valid_q || i_coef_ready;
    assign last_nib_c  = (ptr_q == PTR_W'(N_NIB - 1));
    assign last_coef_c = (cnt_q == CNT_W'(N_COEF - 1));

    // The buffer shifts right as it is scanned, so the current nibble is
    // always in the low four bits and no wide nibble mux is needed.
    always_comb begin
        nib_c      = buf_q[3:0];
        mod5_c     = nib_c - ((nib_c >= 4'd5)  ? 4'd5 : 4'd0)
                           - ((nib_c >= 4'd10) ? 4'd5 : 4'd0);
        nib_ok_c   = 1'b0;
        nib_coef_c = '0;
        if (ETA == 4) begin
            nib_ok_c   = (nib_c < 4'd9);
            nib_coef_c = COEF_W'(ETA) - COEF_W'(nib_c);
        end else begin
            nib_ok_c   = (nib_c < 4'd15);
            nib_coef_c = COEF_W'(ETA) - COEF_W'(mod5_c);
        end
    end

    // Control FSM with registered outputs; i_start overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            coef_q  <= '0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            req_q  <= 1'b0;
            if (i_start) begin
                state_q <= WAIT_BLK;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                ptr_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    WAIT_BLK: begin
                        // A coefficient accepted on the last nibble may still be on offer.
                        if (hs_c) valid_q <= 1'b0;
                        if (i_squeeze_valid) begin
                            buf_q   <= i_squeeze_data;
                            ptr_q   <= '0;
                            req_q   <= 1'b1;
                            state_q <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (adv_c) begin
                            buf_q <= buf_q >> 4;
                            ptr_q <= ptr_q + PTR_W'(1);
                            if (nib_ok_c) begin
                                coef_q  <= nib_coef_c;
                                idx_q   <= 8'(cnt_q);
                                valid_q <= 1'b1;
                                cnt_q   <= cnt_q + CNT_W'(1);
                                if (last_coef_c)     state_q <= DRAIN;
                                else if (last_nib_c) state_q <= WAIT_BLK;
                            end else begin
                                if (hs_c)       valid_q <= 1'b0;
                                if (last_nib_c) state_q <= WAIT_BLK;
                            end
                        end
                    end
                    DRAIN: begin
                        if (hs_c) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_squeeze_req = req_q;
    assign o_coef_valid  = valid_q;
    assign o_coef        = coef_q;
    assign o_coef_idx    = idx_q;

endmodule

// File: doc/shake_eta_sampler.md
# shake_eta_sampler

Rejection sampler that sits directly downstream of the SHAKE256 squeeze port in the keygen datapath. It turns squeezed XOF blocks into 256 small secret coefficients in [-ETA, ETA] using Dilithium-style nibble rejection. It latches each squeezed block and immediately requests the next one so the permutation overlaps with scanning. Coefficients go out one at a time on a valid/ready stream to the polynomial store.

## Interface
- OUTPUT_LEN_BYTES, 128: bytes per squeezed block; must match the XOF output width.
- ETA, 2: noise bound; legal values are 2 and 4 only.
- N_COEF, 256: coefficients per polynomial.
- COEF_W, 4: output coefficient width, two's complement.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse; begin a new polynomial (aborts any run in progress).
- o_busy  out  1  high from the edge after i_start until o_done.
- o_done  out  1  one-cycle pulse after the last coefficient handshake.
- o_squeeze_req  out  1  one-cycle pulse to XOF i_squeeze_req; requests the next block.
- i_squeeze_valid  in  1  XOF block available.
- i_squeeze_data  in  OUTPUT_LEN_BYTES*8  XOF block; byte k is bits [8k+7:8k].
- o_coef_valid  out  1  coefficient valid.
- o_coef  out  COEF_W  coefficient value, two's complement.
- o_coef_idx  out  8  index of the coefficient, 0..N_COEF-1.
- i_coef_ready  in  1  consumer accepts; a handshake is o_coef_valid && i_coef_ready.

## Operation
- States:
  - IDLE: waits for i_start.
  - WAIT_BLK: waits for a block.
  - SCAN: examines nibbles.
  - DRAIN: waits for the final handshake.
- i_start, from any state, on the same edge:
  - state <= WAIT_BLK, o_busy <= 1, coefficient count <= 0, nibble pointer <= 0.
  - o_coef_valid <= 0, o_squeeze_req <= 0.
- WAIT_BLK with i_squeeze_valid=1:
  - buffer <= i_squeeze_data, pointer <= 0, o_squeeze_req <= 1 for exactly one cycle, state <= SCAN.
- Nibble order: pointer p in 0..2*OUTPUT_LEN_BYTES-1. Nibble p = buffer[4p+3:4p], i.e. low nibble of each byte first, bytes ascending.
- SCAN advance condition: (!o_coef_valid || i_coef_ready). When it holds:
  - Examine nibble b = nibble[p], then p++.
  - ETA=2: accept iff b<15; coef = 2 - (b mod 5). Compute mod 5 without a divider as b - 5*(b>=5) - 5*(b>=10).
  - ETA=4: accept iff b<9; coef = 4 - b.
  - Accept: o_coef <= coef, o_coef_idx <= count, o_coef_valid <= 1, count++.
  - Reject: o_coef_valid <= 0 if a handshake occurred this cycle, otherwise unchanged.
- Stall: SCAN holds p while o_coef_valid && !i_coef_ready. o_coef and o_coef_idx stay stable while stalled.
- Accepting coefficient N_COEF-1 moves to DRAIN. The remaining nibbles are discarded and no further o_squeeze_req is issued.
- Block exhausted: when the last nibble is examined without completing, state <= WAIT_BLK. The next block is latched as soon as i_squeeze_valid=1.
- DRAIN: on the handshake, o_coef_valid <= 0, o_done <= 1 (one cycle), o_busy <= 0, state <= IDLE.
- Prefetch invariant: the XOF keeps valid high for one cycle after seeing o_squeeze_req. WAIT_BLK is never re-entered within 2*OUTPUT_LEN_BYTES cycles of a latch, so a stale block is never re-latched.

## Timing
- Reset values: all outputs 0, state IDLE, count 0, pointer 0.
- Block latched on edge E: o_squeeze_req is high during cycle E..E+1, nibble 0 is examined at E+1, and the first coefficient is valid after E+1 if nibble 0 is accepted.
- Throughput: one nibble per cycle when unstalled. A block scan takes 2*OUTPUT_LEN_BYTES cycles plus stall cycles.
- o_done asserts on the edge of the final handshake and lasts one cycle. o_busy falls on the same edge.
- i_start simultaneous with a handshake: i_start wins. The handshake still completes on the consumer side, but the old run is discarded.
- i_squeeze_valid is ignored outside WAIT_BLK.

## Test plan
- ETA=2, block of all bytes 0x21 -> coefficients alternate 1,0 (nibble 1 gives 1, nibble 2 gives 0). Idx 0..255 consumes exactly 256 nibbles. One o_squeeze_req is issued, then o_done.
- ETA=2, first block all 0xFF, then second block all 0x43 -> no coefficient from block 1. A second o_squeeze_req is seen 256 cycles after the first latch. From block 2, coefficients alternate -1 (4'hF, from nibble 3) and -2 (4'hE, from nibble 4).
- ETA=4, byte 0x90 -> nibble 0 gives coef 4 (4'h4), nibble 9 is rejected. Byte 0x18 -> coefs -4 (4'hC) then 3 (4'h3).
- Backpressure: hold i_coef_ready=0 for 10 cycles at idx 5 -> o_coef and o_coef_idx stay stable and the pointer does not move. On release, idx 6 follows in the next cycle, with no loss or duplication over all 256.
- Abort: i_start at idx 100 -> o_coef_valid drops next cycle and the block is re-waited. The new run starts at idx 0 and produces exactly 256 coefficients followed by one o_done.
- Async reset mid-SCAN -> all outputs 0 immediately. The block then stays IDLE, ignoring i_squeeze_valid, until i_start.
